cgra_imem_bank_loader: RTL
==========================

// Module: cgra_imem_bank_loader
// PURPOSE
//  Parametrised instruction-memory bank for the CGRA: NUM_ID decoder memories (I_WIDTH) plus NUM_IMM
//  immediate memories (I_IMM_WIDTH), generated per channel. Replaces per-memory write strobes with a
//  command/stream load engine: host issues (channel, base, count), then streams words via valid/ready.
//  Core-side read ports remain one per channel with 1-cycle registered latency.
// PARAMETERS
//  I_WIDTH            12   decoder instruction width
//  I_IMM_WIDTH        33   immediate instruction width; also load stream width
//  IM_MEM_ADDR_WIDTH  8    address bits per memory (depth = 2**IM_MEM_ADDR_WIDTH)
//  NUM_ID             10   decoder channels, indices 0..NUM_ID-1
//  NUM_IMM            4    immediate channels, indices NUM_ID..NUM_ID+NUM_IMM-1
//  CH_WIDTH           5    command channel-select width; must satisfy 2**CH_WIDTH >= NUM_ID+NUM_IMM
// PORTS
//  iClk            in   1                          clock
//  iReset          in   1                          async reset, active-high
//  iCmd_Valid      in   1                          load command valid
//  oCmd_Ready      out  1                          command accepted when Valid&Ready
//  iCmd_Channel    in   CH_WIDTH                   target memory channel
//  iCmd_BaseAddr   in   IM_MEM_ADDR_WIDTH          first write address
//  iCmd_Count      in   IM_MEM_ADDR_WIDTH+1        words to write (0..depth)
//  iData_Valid     in   1                          load word valid
//  oData_Ready     out  1                          word accepted when Valid&Ready
//  iData           in   I_IMM_WIDTH                load word (ID channels use [I_WIDTH-1:0])
//  oBusy           out  1                          load engine not IDLE
//  oDone           out  1                          1-cycle pulse: load finished
//  oError          out  1                          sticky: bad channel seen; cleared on next accepted cmd
//  iIM_ReadEnable  in   NUM_ID+NUM_IMM             per-channel read enable
//  iIM_ReadAddress in   (NUM_ID+NUM_IMM)*IM_MEM_ADDR_WIDTH  packed read addresses, channel 0 at LSB
//  oIM_ReadData    out  NUM_IMM*I_IMM_WIDTH+NUM_ID*I_WIDTH  packed: ID channels at LSBs, then IMM
// BEHAVIOUR
//  Reset (async): state IDLE; oCmd_Ready=1, oData_Ready=0, oBusy=0, oDone=0, oError=0; all read
//   data registers 0. Memory contents are not reset.
//  FSM IDLE/LOAD/DONE:
//   IDLE: oCmd_Ready=1. On accept: latch channel, addr<=base, remaining<=count, clear oError.
//    If channel >= NUM_ID+NUM_IMM: set oError, go DONE, write nothing. If count==0: go DONE.
//    Otherwise go LOAD.
//   LOAD: oCmd_Ready=0, oData_Ready=1. Each accepted word writes mem[ch][addr] at that edge;
//    addr<=addr+1 (wraps modulo depth); remaining<=remaining-1. Accepting the word with
//    remaining==1 goes to DONE. Data offered in IDLE/DONE is not accepted (oData_Ready=0).
//   DONE: oDone=1 for exactly this cycle; oBusy=1; then IDLE.
//  oBusy=1 in LOAD and DONE. Back-to-back commands: the earliest next accept is the cycle after DONE.
//  Write data truncation: ID channels store iData[I_WIDTH-1:0]; IMM channels store all bits.
//  Read: if iIM_ReadEnable[c] at edge, oIM_ReadData slice c <= mem[c][addr_c] (1-cycle latency);
//   if not enabled, slice holds its previous value. Reads on all channels run concurrently with loads.
//  Same-cycle read and write to the same channel/address: read returns OLD contents (read-first);
//   the new value is visible from the next read.
//  Count==depth with wrap: all locations written exactly once, ending at base-1.
//  Reset mid-LOAD: returns to IDLE immediately; words already written remain, the rest are not written;
//   no oDone pulse.
// TESTING
//  1. Cmd ch=0 base=0x10 cnt=3, data 0x123,0x456,0x789 -> ch0 reads at 0x10..0x12 return 0x123,0x456,0x789;
//     oDone pulses once, 1 cycle after 3rd word accepted.
//  2. Cmd ch=NUM_ID (IMM0) base=0xFE cnt=4, data 0x1_0000_0001+k -> addrs 0xFE,0xFF,0x00,0x01 hold
//     those 33-bit values (wrap verified); ID-channel writes of 0x1FFF store 0xFFF.
//  3. Cmd ch=20 (>=14) -> oError=1, oDone pulse, no memory changes; next valid cmd clears oError.
//  4. During LOAD to ch3 addr 0x40, read ch3 addr 0x40 on the write cycle -> old value; next read
//     returns the new value; ch5 reads in the same cycles are unaffected.
//  5. iData_Valid toggled 1/0 randomly with cnt=8 -> exactly 8 writes, oBusy high throughout;
//     cnt=0 -> DONE directly, no writes.
//  6. Assert iReset after 2 of 5 words -> all outputs at reset values in the same cycle;
//     2 words written, remainder unchanged, no oDone.

Source files
------------

// File: rtl/cgra_imem_bank_loader.sv
`default_nettype none
// ============================================================================
// Module  : cgra_imem_bank_loader
// Brief   : CGRA instruction-memory bank (decoder + immediate channels) filled
//           by a command/stream load engine; 1-cycle registered read ports.
// Rev     : 1.0
// ============================================================================
module cgra_imem_bank_loader #(
  parameter int I_WIDTH           = 12,
  parameter int I_IMM_WIDTH       = 33,
  parameter int IM_MEM_ADDR_WIDTH = 8,
  parameter int NUM_ID            = 10,
  parameter int NUM_IMM           = 4,
  parameter int CH_WIDTH          = 5
) (
  input  logic                                          iClk,
  input  logic                                          iReset,
  input  logic                                          iCmd_Valid,
  output logic                                          oCmd_Ready,
  input  logic [CH_WIDTH-1:0]                           iCmd_Channel,
  input  logic [IM_MEM_ADDR_WIDTH-1:0]                  iCmd_BaseAddr,
  input  logic [IM_MEM_ADDR_WIDTH:0]                    iCmd_Count,
  input  logic                                          iData_Valid,
  output logic                                          oData_Ready,
  input  logic [I_IMM_WIDTH-1:0]                        iData,
  output logic                                          oBusy,
  output logic                                          oDone,
  output logic                                          oError,
  input  logic [NUM_ID+NUM_IMM-1:0]                     iIM_ReadEnable,
  input  logic [(NUM_ID+NUM_IMM)*IM_MEM_ADDR_WIDTH-1:0] iIM_ReadAddress,
  output logic [NUM_IMM*I_IMM_WIDTH+NUM_ID*I_WIDTH-1:0] oIM_ReadData
);

  localparam int AW     = IM_MEM_ADDR_WIDTH;
  localparam int DEPTH  = 2**AW;
  localparam int NUM_CH = NUM_ID + NUM_IMM;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [CH_WIDTH-1:0] ch_q;
  logic [AW-1:0]       addr_q;
  logic [AW:0]         rem_q;
  logic                cmd_ready_q;
  logic                data_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;

  logic w_cmd_fire;
  logic w_data_fire;
  logic w_bad_ch;

  assign w_cmd_fire  = iCmd_Valid & cmd_ready_q;
  assign w_data_fire = iData_Valid & data_ready_q;
  assign w_bad_ch    = ({1'b0, iCmd_Channel} >= (CH_WIDTH+1)'(NUM_CH));

  assign oCmd_Ready  = cmd_ready_q;
  assign oData_Ready = data_ready_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oError      = error_q;

  // Handshake outputs are registered alongside the state so they change only on clock edges.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      cmd_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_cmd_fire) begin
            ch_q        <= iCmd_Channel;
            addr_q      <= iCmd_BaseAddr;
            rem_q       <= iCmd_Count;
            error_q     <= w_bad_ch;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (w_bad_ch || (iCmd_Count == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_LOAD;
              data_ready_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_data_fire) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == (AW+1)'(1)) begin
              state_q      <= S_DONE;
              data_ready_q <= 1'b0;
              done_q       <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= S_IDLE;
          data_ready_q <= 1'b0;
          done_q       <= 1'b0;
          busy_q       <= 1'b0;
          cmd_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Array writes use non-blocking assignment, so a same-edge read returns the old word.
  for (genvar c = 0; c < NUM_ID; c++) begin : g_id
    logic [I_WIDTH-1:0] mem_q [DEPTH];
    logic [I_WIDTH-1:0] rd_data_q;
    logic               w_we;

    assign w_we = w_data_fire && (ch_q == CH_WIDTH'(c));

    always_ff @(posedge iClk) begin
      if (w_we) mem_q[addr_q] <= iData[I_WIDTH-1:0];
    end

    always_ff @(posedge iClk or posedge iReset) begin
      if (iReset)                 rd_data_q <= '0;
      else if (iIM_ReadEnable[c]) rd_data_q <= mem_q[iIM_ReadAddress[c*AW +: AW]];
    end

    assign oIM_ReadData[c*I_WIDTH +: I_WIDTH] = rd_data_q;
  end

  for (genvar j = 0; j < NUM_IMM; j++) begin : g_imm
    logic [I_IMM_WIDTH-1:0] mem_q [DEPTH];
    logic [I_IMM_WIDTH-1:0] rd_data_q;
    logic                   w_we;

    assign w_we = w_data_fire && (ch_q == CH_WIDTH'(NUM_ID + j));

    always_ff @(posedge iClk) begin
      if (w_we) mem_q[addr_q] <= iData;
    end

    always_ff @(posedge iClk or posedge iReset) begin
      if (iReset)                          rd_data_q <= '0;
      else if (iIM_ReadEnable[NUM_ID + j]) rd_data_q <= mem_q[iIM_ReadAddress[(NUM_ID+j)*AW +: AW]];
    end

    assign oIM_ReadData[NUM_ID*I_WIDTH + j*I_IMM_WIDTH +: I_IMM_WIDTH] = rd_data_q;
  end

endmodule
`default_nettype wire
